// File: rtl/xfer_buffer_pkg.sv
// xfer_buffer_pkg: state encodings and width helpers shared by the xfer_buffer_pool files.
package xfer_buffer_pkg;
  typedef enum logic {H_IDLE, H_FILL} host_st_e;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_FLUSH} drain_st_e;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} buf_st_e;
  localparam int GS_W = 8;
  localparam int GS_MAX = 255;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xfer_buf_ram.sv
// xfer_buf_ram: simple dual-port synchronous RAM; the read port only updates when re_i is high,
// so a stalled consumer sees its last read word held.
module xfer_buf_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/xfer_buffer_pool.sv
// xfer_buffer_pool: NUM_BUFS host-filled buffers drained to TBM in commit order with backpressure.
// Define XFER_PARITY_EN to store an even-parity bit per word and flag bad beats on parity_err.
module xfer_buffer_pool
  import xfer_buffer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 1024,
  parameter int NUM_BUFS  = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clock_fpga,
  input  logic              reset,
  input  logic              host_select,
  input  logic              hwrite_enable,
  input  logic [DATA_W-1:0] hostdata_in,
  output logic              host_wready,
  input  logic              gs_select,
  input  logic              gs_write_enable,
  output logic [7:0]        gs_out,
  output logic              gs_out_enable,
  input  logic              xfer_buf_select,
  input  logic              mwrite_enable,
  input  logic [ADDR_W-1:0] tbm_address,
  output logic              tbm_wr_en,
  output logic [ADDR_W-1:0] tbm_wr_addr,
  output logic [DATA_W-1:0] tbm_wr_data,
  input  logic              tbm_ready,
  output logic              xfer_complete,
  output logic              buf_overflow
`ifdef XFER_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int IW = idx_w(NUM_BUFS);
  localparam int PW = idx_w(BUF_DEPTH);
  localparam int CW = idx_w(NUM_BUFS + 1);
`ifdef XFER_PARITY_EN
  localparam int RW = DATA_W + 1;
`else
  localparam int RW = DATA_W;
`endif
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);

  host_st_e          h_q, h_d;
  drain_st_e         d_q, d_d;
  buf_st_e           bst_q [NUM_BUFS];
  buf_st_e           bst_d [NUM_BUFS];
  logic [IW-1:0]     fifo_q [NUM_BUFS];
  logic [IW-1:0]     fifo_d [NUM_BUFS];
  logic [IW-1:0]     hbuf_q, hbuf_d, dbuf_q, dbuf_d, fh_q, fh_d, ft_q, ft_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, acc_q, acc_d;
  logic [CW-1:0]     free_q, free_d, fn_q, fn_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [RW-1:0]     odata_q, odata_d;
  logic [GS_W-1:0]   gs_q, gs_d;
  logic              v1_q, v1_d, oen_q, oen_d, xc_q, xc_d, ovf_q, ovf_d, gse_q, gse_d;
  logic              wr_try, wr_acc, alloc, commit, pop, stall, beat, rd_en, finish;
  logic [IW-1:0]     low_free;
  logic [RW-1:0]     ram_wdata, ram_rdata;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (p == IW'(NUM_BUFS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    low_free = '0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) if (bst_q[i] == B_FREE) low_free = IW'(i);
  end

  assign host_wready = (h_q == H_FILL) | (free_q != '0);
  assign wr_try      = host_select & hwrite_enable;
  assign wr_acc      = wr_try & host_wready;
  assign alloc       = wr_acc & (h_q == H_IDLE);
  assign commit      = wr_acc & (h_q == H_FILL) & (wptr_q == LAST);
  assign pop         = (d_q == D_IDLE) & xfer_buf_select & mwrite_enable & (fn_q != '0);
  assign stall       = oen_q & ~tbm_ready;
  assign beat        = oen_q & tbm_ready;
  assign rd_en       = (d_q == D_RUN) & ~stall;
  assign finish      = beat & (d_q == D_FLUSH) & (acc_q == LAST);
`ifdef XFER_PARITY_EN
  assign ram_wdata   = {^hostdata_in, hostdata_in};
  assign parity_err  = beat & (^odata_q);
`else
  assign ram_wdata   = hostdata_in;
`endif

  xfer_buf_ram #(.W(RW), .DEPTH(NUM_BUFS * BUF_DEPTH), .AW(IW + PW)) u_ram (
    .clk_i   (clock_fpga),
    .we_i    (wr_acc),
    .waddr_i ({alloc ? low_free : hbuf_q, wptr_q}),
    .wdata_i (ram_wdata),
    .re_i    (rd_en),
    .raddr_i ({dbuf_q, rptr_q}),
    .rdata_o (ram_rdata)
  );

  // Buffer-state transitions always touch distinct entries, so they can all land in one cycle.
  always_comb begin
    h_d    = h_q;
    hbuf_d = hbuf_q;
    d_d    = d_q;
    dbuf_d = dbuf_q;
    base_d = base_q;
    bst_d  = bst_q;
    fifo_d = fifo_q;
    fh_d   = pop ? nxt(fh_q) : fh_q;
    ft_d   = commit ? nxt(ft_q) : ft_q;
    fn_d   = fn_q + CW'(commit) - CW'(pop);
    free_d = free_q + CW'(finish) - CW'(alloc);
    wptr_d = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;
    acc_d  = beat ? acc_q + 1'b1 : acc_q;
    if (alloc) begin
      h_d             = H_FILL;
      hbuf_d          = low_free;
      bst_d[low_free] = B_FILLING;
    end
    if (commit) begin
      h_d           = H_IDLE;
      bst_d[hbuf_q] = B_FULL;
      fifo_d[ft_q]  = hbuf_q;
    end
    if (pop) begin
      d_d                 = D_RUN;
      dbuf_d              = fifo_q[fh_q];
      bst_d[fifo_q[fh_q]] = B_DRAINING;
      base_d              = tbm_address;
    end
    if (rd_en && rptr_q == LAST) d_d = D_FLUSH;
    if (finish) begin
      d_d           = D_IDLE;
      bst_d[dbuf_q] = B_FREE;
    end
  end

  assign v1_d    = stall ? v1_q : rd_en;
  assign oen_d   = stall ? oen_q : v1_q;
  assign odata_d = (!stall && v1_q) ? ram_rdata : odata_q;
  assign xc_d    = finish;
  assign ovf_d   = ovf_q | (wr_try & ~host_wready);
  assign gse_d   = gs_select & gs_write_enable;
  assign gs_d    = !gse_d ? gs_q : (int'(free_q) > GS_MAX) ? GS_W'(GS_MAX) : GS_W'(free_q);

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      h_q     <= H_IDLE;
      d_q     <= D_IDLE;
      bst_q   <= '{default: B_FREE};
      fifo_q  <= '{default: '0};
      hbuf_q  <= '0;
      dbuf_q  <= '0;
      fh_q    <= '0;
      ft_q    <= '0;
      fn_q    <= '0;
      free_q  <= CW'(NUM_BUFS);
      wptr_q  <= '0;
      rptr_q  <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      odata_q <= '0;
      v1_q    <= 1'b0;
      oen_q   <= 1'b0;
      xc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      gse_q   <= 1'b0;
      gs_q    <= '0;
    end else begin
      h_q     <= h_d;
      d_q     <= d_d;
      bst_q   <= bst_d;
      fifo_q  <= fifo_d;
      hbuf_q  <= hbuf_d;
      dbuf_q  <= dbuf_d;
      fh_q    <= fh_d;
      ft_q    <= ft_d;
      fn_q    <= fn_d;
      free_q  <= free_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      odata_q <= odata_d;
      v1_q    <= v1_d;
      oen_q   <= oen_d;
      xc_q    <= xc_d;
      ovf_q   <= ovf_d;
      gse_q   <= gse_d;
      gs_q    <= gs_d;
    end
  end

  assign tbm_wr_en     = oen_q;
  assign tbm_wr_addr   = base_q + ADDR_W'(acc_q);
  assign tbm_wr_data   = odata_q[DATA_W-1:0];
  assign xfer_complete = xc_q;
  assign buf_overflow  = ovf_q;
  assign gs_out        = gs_q;
  assign gs_out_enable = gse_q;
endmodule

// File: tb/tb_xfer_buffer_pool.sv
// tb_xfer_buffer_pool: directed and randomized stimulus against a queue-based model of the pool
// (free count, commit-ordered word stream, drain latency and backpressure).
module tb_xfer_buffer_pool;
  localparam int DEPTH = 1024;
  localparam int NB    = 4;

  logic        clock_fpga = 1'b0;
  logic        reset = 1'b0;
  logic        host_select = 1'b0, hwrite_enable = 1'b0;
  logic [31:0] hostdata_in = '0;
  logic        host_wready;
  logic        gs_select = 1'b0, gs_write_enable = 1'b0;
  logic [7:0]  gs_out;
  logic        gs_out_enable;
  logic        xfer_buf_select = 1'b0, mwrite_enable = 1'b0;
  logic [31:0] tbm_address = '0;
  logic        tbm_wr_en;
  logic [31:0] tbm_wr_addr, tbm_wr_data;
  logic        tbm_ready = 1'b0;
  logic        xfer_complete, buf_overflow;
`ifdef XFER_PARITY_EN
  logic        parity_err;
`endif

  xfer_buffer_pool dut (
    .clock_fpga      (clock_fpga),
    .reset           (reset),
    .host_select     (host_select),
    .hwrite_enable   (hwrite_enable),
    .hostdata_in     (hostdata_in),
    .host_wready     (host_wready),
    .gs_select       (gs_select),
    .gs_write_enable (gs_write_enable),
    .gs_out          (gs_out),
    .gs_out_enable   (gs_out_enable),
    .xfer_buf_select (xfer_buf_select),
    .mwrite_enable   (mwrite_enable),
    .tbm_address     (tbm_address),
    .tbm_wr_en       (tbm_wr_en),
    .tbm_wr_addr     (tbm_wr_addr),
    .tbm_wr_data     (tbm_wr_data),
    .tbm_ready       (tbm_ready),
    .xfer_complete   (xfer_complete),
`ifdef XFER_PARITY_EN
    .parity_err      (parity_err),
`endif
    .buf_overflow    (buf_overflow)
  );

  always #5 clock_fpga = ~clock_fpga;

  int total = 0, bad = 0;
  int free_n, n_cq, fill_cnt, d_idx, since, nbeats;
  bit filling, draining, ovf_m, xc_m, gse_m;
  logic [7:0]  gs_m;
  logic [31:0] base_m;
  logic [31:0] words[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_n = NB; n_cq = 0; fill_cnt = 0; d_idx = 0; since = 0; nbeats = 0;
    filling = 0; draining = 0; ovf_m = 0; xc_m = 0; gse_m = 0; gs_m = '0; base_m = '0;
    words.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wready"}, host_wready, 1);
    chk({tag, "_wr_en"}, tbm_wr_en, 0);
    chk({tag, "_addr"}, tbm_wr_addr, 0);
    chk({tag, "_data"}, tbm_wr_data, 0);
    chk({tag, "_xc"}, xfer_complete, 0);
    chk({tag, "_gs"}, gs_out, 0);
    chk({tag, "_gse"}, gs_out_enable, 0);
    chk({tag, "_ovf"}, buf_overflow, 0);
  endtask

  // Called at a falling edge: check outputs, drive the next inputs, advance the model over the rising edge.
  task automatic step(input bit w, input logic [31:0] wd, input bit q, input bit req,
                      input logic [31:0] ta, input bit rdy);
    bit alloc, commit, pop, beat, fin;
    logic [31:0] ea;
    chk("host_wready", host_wready, filling || free_n > 0);
    chk("tbm_wr_en", tbm_wr_en, draining && since >= 2);
    chk("xfer_complete", xfer_complete, xc_m);
    chk("gs_out_enable", gs_out_enable, gse_m);
    chk("gs_out", gs_out, gs_m);
    chk("buf_overflow", buf_overflow, ovf_m);
`ifdef XFER_PARITY_EN
    chk("parity_err", parity_err, 0);
`endif
    host_select = w; hwrite_enable = w; hostdata_in = wd;
    gs_select = q; gs_write_enable = q;
    xfer_buf_select = req; mwrite_enable = req;
    tbm_address = ta; tbm_ready = rdy;
    beat = draining && since >= 2 && rdy;
    if (beat) begin
      ea = base_m + 32'(d_idx);
      chk("tbm_wr_addr", tbm_wr_addr, ea);
      chk("tbm_wr_data", tbm_wr_data, words.size() > 0 ? words.pop_front() : 32'hX);
    end
    gse_m = q; xc_m = 0;
    if (q) gs_m = 8'(free_n);
    alloc = 0; commit = 0; fin = 0;
    if (w) begin
      if (filling || free_n > 0) begin
        if (!filling) begin filling = 1; alloc = 1; end
        words.push_back(wd);
        fill_cnt++;
        if (fill_cnt == DEPTH) begin filling = 0; fill_cnt = 0; commit = 1; end
      end else ovf_m = 1;
    end
    pop = !draining && req && n_cq > 0;
    if (beat) begin
      nbeats++;
      if (d_idx == DEPTH - 1) fin = 1;
      d_idx++;
    end
    if (draining) since++;
    if (pop) begin draining = 1; since = 0; d_idx = 0; base_m = ta; n_cq--; end
    if (commit) n_cq++;
    if (fin) begin draining = 0; xc_m = 1; free_n++; end
    if (alloc) free_n--;
    @(negedge clock_fpga);
  endtask

  task automatic drain_all(input logic [31:0] ta, input int mode);
    int g = 0;
    bit r;
    while ((n_cq > 0 || draining) && g < 20000) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 4 == 0 || g % 4 == 3) : ($urandom_range(0, 2) != 0);
      step(0, 0, 0, 1, ta, r);
      g++;
    end
    chk("drain_bound", g < 20000, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    model_reset();
    repeat (3) @(negedge clock_fpga);
    chk_idle("reset");
    reset = 1'b1;
    @(negedge clock_fpga);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // single buffer, full-rate drain
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    nbeats = 0;
    drain_all(32'h1000, 0);
    chk("beats_plain", nbeats, DEPTH);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // backpressure pattern 1,0,0,1
    for (int i = 0; i < DEPTH; i++) step(1, i ^ 32'h5A5A_0000, 0, 0, 0, 1);
    nbeats = 0;
    drain_all(32'h8000, 1);
    chk("beats_bp", nbeats, DEPTH);
    // fill one buffer while draining the previous one
    for (int i = 0; i < DEPTH; i++) step(1, 32'h3000_0000 + i, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 8; i++) step(i < DEPTH, 32'h5000_0000 + i, 0, 1, 32'h2000, 1);
    step(0, 0, 1, 1, 32'h2000, 1);
    drain_all(32'h3000, 2);
    // randomized concurrent traffic
    for (int c = 0; c < 6000; c++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
    g = 0;
    while ((filling || n_cq > 0 || draining) && g < 20000) begin
      step(filling, $urandom, 0, 1, $urandom, 1);
      g++;
    end
    chk("flush_bound", g < 20000, 1);
    step(0, 0, 1, 0, 0, 1);
    // all buffers full, then an overflowing write; drain order and address wrap
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < DEPTH; i++) step(1, (i == 0) ? (32'hA000_0000 | (k << 24)) : i, 0, 0, 0, 1);
    chk("wready_full", host_wready, 0);
    step(1, 32'hDEAD_BEEF, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("overflow_set", buf_overflow, 1);
    nbeats = 0;
    drain_all(32'hFFFF_FE00, 2);
    chk("beats_all", nbeats, NB * DEPTH);
    step(0, 0, 1, 0, 0, 1);
    // reset in the middle of a drain
    for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0, 0, 1);
    g = 0;
    while (!(draining && d_idx == 500) && g < 3000) begin
      step(0, 0, 0, 1, 32'h4000, 1);
      g++;
    end
    chk("mid_bound", g < 3000, 1);
    reset = 1'b0;
    host_select = 0; hwrite_enable = 0; gs_select = 0; gs_write_enable = 0;
    xfer_buf_select = 0; mwrite_enable = 0; tbm_ready = 0;
    #1;
    chk_idle("midrst");
    @(negedge clock_fpga);
    reset = 1'b1;
    model_reset();
    @(negedge clock_fpga);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xfer_buffer_pool.md
Name: xfer_buffer_pool

Overview:
- Parametrised successor to the single host-to-TBM transfer buffer.
- Holds NUM_BUFS independent buffers, each BUF_DEPTH words of DATA_W bits, in a single clock domain.
- The host side fills free buffers, and a status query reports how many buffers are free.
- The drain side streams full buffers to TBM in commit order, with backpressure, and pulses xfer_complete per buffer.

Parameters:
- DATA_W, 32, host/TBM data width.
- BUF_DEPTH, 1024, words per buffer (power of 2, >=4).
- NUM_BUFS, 4, number of buffers (2..16).
- ADDR_W, 32, TBM address width.

Ports:
- clock_fpga  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_select  in  1  host write qualifier.
- hwrite_enable  in  1  host write strobe; a word is accepted when host_select & hwrite_enable & host_wready.
- hostdata_in  in  DATA_W  host write data.
- host_wready  out  1  a buffer is allocated or allocatable.
- gs_select  in  1  status query qualifier.
- gs_write_enable  in  1  status query strobe.
- gs_out  out  8  free-buffer count.
- gs_out_enable  out  1  gs_out valid, 1-cycle pulse.
- xfer_buf_select  in  1  drain qualifier.
- mwrite_enable  in  1  drain start request.
- tbm_address  in  ADDR_W  TBM base address, latched at drain start.
- tbm_wr_en  out  1  TBM write valid.
- tbm_wr_addr  out  ADDR_W  TBM write address.
- tbm_wr_data  out  DATA_W  TBM write data.
- tbm_ready  in  1  TBM accepts a word when tbm_wr_en & tbm_ready.
- xfer_complete  out  1  1-cycle pulse after the last word of a buffer is accepted.
- buf_overflow  out  1  sticky; set by a host write attempted while no buffer is free.

Behaviour:
- Reset: every buffer is FREE; all outputs are 0 except host_wready=1; the commit queue is empty; both FSMs are idle. Reset asserted mid-operation aborts both sides immediately, with no xfer_complete.
- Buffer state per entry: FREE -> FILLING -> FULL -> DRAINING -> FREE.
- Host FSM H_IDLE/H_FILL:
  - In H_IDLE, the first accepted write allocates the lowest-index FREE buffer, writes word 0 and enters H_FILL.
  - The write pointer increments per accepted word.
  - On word BUF_DEPTH-1 the buffer goes FULL, its index is pushed to the commit FIFO (depth NUM_BUFS), and the FSM returns to H_IDLE.
- host_wready = H_FILL, or (H_IDLE and free_count>0). A write with host_wready=0 is dropped and sets buf_overflow.
- Status query: gs_select & gs_write_enable sampled at edge N gives gs_out_enable=1 and gs_out=free_count at edge N+1. The count is the registered value at edge N, saturated to 255. gs_out holds its value between queries.
- Drain FSM D_IDLE/D_RUN/D_FLUSH:
  - In D_IDLE, xfer_buf_select & mwrite_enable with a non-empty commit FIFO pops the head index, latches tbm_address, marks that buffer DRAINING and enters D_RUN. A request with an empty FIFO is ignored; the level-held request retries every cycle.
  - The RAM has 1-cycle synchronous read latency. The first tbm_wr_en rises 2 cycles after the start edge.
  - Read advance and output registers hold while tbm_wr_en & !tbm_ready (no data loss, no duplication).
  - tbm_wr_addr = base + word index, wrapping modulo 2^ADDR_W.
  - After the last word is accepted: xfer_complete pulses for 1 cycle, the buffer goes FREE, and the FSM returns to D_IDLE. A held request restarts no earlier than the next cycle.
- Simultaneous events:
  - A buffer freed by drain in cycle N is not allocatable until N+1.
  - Host commit and drain pop in the same cycle: the pop sees the prior FIFO contents, and the push still lands.
  - free_count updates by net change (+1 free, -1 alloc) in one cycle.
- Filling and draining different buffers concurrently is required. The same buffer is never both.

Optional Feature:
- Macro XFER_PARITY_EN.
- Defined: each stored word carries an even-parity bit computed on write and checked on drain output. Output port parity_err (1 bit) pulses, aligned with the offending tbm_wr_en & tbm_ready beat. Data is still delivered.
- Undefined: no parity storage, no parity_err port. All other behaviour is identical.

Decomposition:
- Package xfer_buffer_pkg:
  - host FSM state encodings (H_IDLE, H_FILL);
  - drain FSM state encodings (D_IDLE, D_RUN, D_FLUSH);
  - buffer-state encodings (B_FREE, B_FILLING, B_FULL, B_DRAINING);
  - width helper constants derived from BUF_DEPTH/NUM_BUFS.
- Sub-module xfer_buf_ram:
  - simple dual-port synchronous RAM, NUM_BUFS*BUF_DEPTH words;
  - one write port and one read port, read enable gated for stalls;
  - width DATA_W, or DATA_W+1 with parity.

Test Plan:
- Query after reset: gs_select=gs_write_enable=1 for one cycle -> next cycle gs_out_enable=1, gs_out=4.
- Fill one buffer with 0..1023, query -> gs_out=3. Drain with tbm_address=0x1000, tbm_ready=1 -> 1024 beats, addr 0x1000..0x13FF, data 0..1023, xfer_complete once, gs_out returns to 4.
- Backpressure: tbm_ready toggled 1,0,0,1 pattern during drain -> data/address sequence unchanged, no gaps or repeats, exactly 1024 accepted beats.
- Fill all 4 buffers, 5th write attempt -> host_wready=0, buf_overflow=1, data dropped. Drain all -> buffers emerge in commit order (tagged first words 0xA0000000..0xA3000000).
- Concurrent: drain buffer 0 while filling buffer 1. Release on last drain beat coincident with an allocation -> allocation takes buffer 1 not 0, free_count consistent.
- Reset_n asserted mid-drain at beat 500 -> all outputs at reset values, gs_out query returns 4; with XFER_PARITY_EN, a forced RAM bit flip -> parity_err pulses on that beat.
